data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Data-memory stage of the MIPS datapath. It sits downstream of the ALU, which supplies the effective address,
//  and upstream of register writeback, which consumes read_data.
//  Handles lw/lh/lhu/lb/lbu/sw/sh/sb over a word-wide RAM with a programmable wait-state count.
//  While an access is outstanding, stall freezes the PC and register writes.
// PARAMETERS
//  DEPTH_WORDS  256           RAM depth in 32-bit words
//  WAIT_STATES  1             extra cycles per access (0..15); 0 = single-cycle access
//  BASE_ADDR    32'h10010000  byte address of word 0 (data segment base)
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   synchronous, active-high reset
//  memread       in   1   load request, from control
//  memwrite      in   1   store request, from control
//  mem_size      in   2   `MEM_BYTE / `MEM_HALF / `MEM_WORD
//  mem_unsigned  in   1   1 = zero-extend loads (lbu/lhu); 0 = sign-extend
//  address       in   32  byte address, from ALU out
//  write_data    in   32  store data (rt); stores take the low byte/half
//  read_data     out  32  extended load result; valid only in the completion cycle, else 0
//  stall         out  1   1 = hold PC and regfile this cycle
//  addr_err      out  1   1 = request rejected (range or alignment); no access performed
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, stall=0, read_data=0, addr_err=0. RAM contents are NOT cleared.
//    RAM is zeroed only at time 0.
//  - Request is the level (memread|memwrite), sampled while the state is IDLE.
//  - Upstream holds all inputs stable while stall=1.
//  - Word index = (address-BASE_ADDR)>>2. Index >= DEPTH_WORDS, or address < BASE_ADDR, is out of range:
//    addr_err=1 for that cycle, stall=0, no write, read_data=0.
//  - FSM states IDLE and BUSY; cnt is a 4-bit counter.
//    IDLE, valid request, WAIT_STATES>0: stall=1, cnt<=WAIT_STATES-1, go to BUSY.
//    BUSY, cnt!=0: stall=1, cnt<=cnt-1.
//    BUSY, cnt==0: completion cycle. stall=0, read_data valid, store commits at the closing posedge, go to IDLE.
//    WAIT_STATES==0: the IDLE request cycle is itself the completion cycle (stall never asserts).
//  - Latency: an access occupies exactly WAIT_STATES+1 cycles. stall is high for the first WAIT_STATES cycles.
//  - Back-to-back accesses: the next instruction's request is sampled in IDLE on the cycle after completion.
//    There are no idle bubbles beyond that.
//  - Byte lanes are little-endian: byte k of a word = bits [8k+7:8k].
//    Stores write only the addressed lanes; the other lanes are preserved.
//    Loads select the lane(s), then sign- or zero-extend per mem_unsigned. A word load ignores mem_unsigned.
//  - memread and memwrite both high: treated as a store; read_data=0.
//  - Reset during BUSY: the pending store is cancelled and the RAM is unchanged. State returns to IDLE and
//    stall=0 on the next cycle.
//  - Input change during BUSY is illegal. The block latches nothing; it uses live inputs at completion.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//    half access with address[0]=1, or word access with address[1:0]!=0, raises addr_err=1.
//    That cycle has stall=0, no access, and read_data=0.
//  DMEM_ALIGN_CHECK_EN undefined:
//    misaligned low bits are forced to 0 (half: a[0]; word: a[1:0]) and the access proceeds.
//    addr_err then flags only out-of-range addresses.
// STRUCTURE
//  - mips.h (shared): `MEM_BYTE=2'd0, `MEM_HALF=2'd1, `MEM_WORD=2'd2. Control drives mem_size with these.
//  - Sub-module dmem_lane_align, purely combinational:
//    store: (addr[1:0], size, write_data, old word) -> merged word.
//    load: (addr[1:0], size, unsigned, word) -> extended result.
//  - Top level holds the RAM array, the FSM, the wait counter and the range/alignment checks.
// TESTING
//  1. WAIT_STATES=1: sw 0xDEADBEEF @0x10010000, then lw @0x10010000.
//     Each access gives stall=1 for 1 cycle then a completion cycle; lw returns 0xDEADBEEF.
//  2. Word 0x10010004 = 0x80FF7F01.
//     lb @..04 -> 0x00000001; lb @..06 -> 0xFFFFFFFF; lbu @..07 -> 0x00000080; lh @..06 -> 0xFFFF80FF.
//  3. Word 0x10010008 = 0x11223344; sb 0xAA @..09, then lw @..08 -> 0x1122AA44 (other lanes intact).
//  4. With DMEM_ALIGN_CHECK_EN: lw @0x10010002 -> addr_err=1, stall=0, read_data=0.
//     Without DMEM_ALIGN_CHECK_EN: the same lw returns the word @0x10010000.
//  5. lw @0x0FFFFFFC and @BASE_ADDR+4*DEPTH_WORDS -> addr_err=1, no stall.
//     sw to those addresses leaves all RAM words unchanged.
//  6. WAIT_STATES=3: reset asserted in the 2nd BUSY cycle of sw 0x12345678 @0x10010010.
//     Next cycle stall=0; lw @0x10010010 then returns the prior value 0x00000000.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared encodings for the data-memory stage.
//   MEM_BYTE/HALF/WORD : mem_size codes driven by control (mips.h values)
//   ST_IDLE/ST_BUSY    : data_mem_ctrl FSM states
//   lane_lo()          : byte offset actually used for an access of a given size
package data_mem_ctrl_pkg;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Low address bits that cannot matter for the size are forced to zero, so a
  // misaligned half/word (when not rejected) lands on its natural boundary.
  function automatic logic [1:0] lane_lo(input logic [1:0] a, input logic [1:0] size);
    case (size)
      MEM_BYTE: return a;
      MEM_HALF: return {a[1], 1'b0};
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
//   addr_lo      in  2   byte offset within the word (already size-aligned)
//   size         in  2   MEM_BYTE / MEM_HALF / MEM_WORD
//   mem_unsigned in  1   zero-extend byte/half loads when set
//   write_data   in  32  store data; low byte/half used for narrow stores
//   word         in  32  current RAM word at the access index
//   merged       out 32  word with the addressed lanes replaced by store data
//   load_data    out 32  selected lane(s), sign/zero extended
module dmem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        mem_unsigned,
  input  logic [31:0] write_data,
  input  logic [31:0] word,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] shifted;

  // Replicate narrow store data across all lanes; byte enables pick the target.
  always_comb begin
    be   = 4'b1111;
    wrep = write_data;
    case (size)
      MEM_BYTE: begin
        be   = 4'b0001 << addr_lo;
        wrep = {4{write_data[7:0]}};
      end
      MEM_HALF: begin
        be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wrep = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign merged[8*k +: 8] = be[k] ? wrep[8*k +: 8] : word[8*k +: 8];
  end

  assign shifted = word >> {addr_lo, 3'b000};

  always_comb begin
    load_data = word;
    case (size)
      MEM_BYTE: load_data = {{24{~mem_unsigned & shifted[7]}},  shifted[7:0]};
      MEM_HALF: load_data = {{16{~mem_unsigned & shifted[15]}}, shifted[15:0]};
      default:  load_data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MIPS data-memory stage with programmable wait states.
//   clk, reset          rising-edge clock, synchronous active-high reset
//   memread, memwrite   load / store request (both high = store)
//   mem_size            MEM_BYTE / MEM_HALF / MEM_WORD
//   mem_unsigned        zero-extend narrow loads
//   address             byte address from the ALU
//   write_data          store data (rt)
//   read_data           extended load result, nonzero only in the completion cycle
//   stall               hold PC and register file this cycle
//   addr_err            request rejected (out of range, or misaligned)
// Build option: define DMEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses; otherwise misaligned low bits are dropped and the access proceeds.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        addr_err
);

  localparam int         IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit         ZERO_WS = (WAIT_STATES == 0);
  localparam logic [3:0] WS_M1   = 4'(WAIT_STATES - 1);

  // Power-up image is all zeros; reset deliberately leaves contents alone.
  logic [31:0] ram [DEPTH_WORDS] = '{default: 32'h0};

  logic [0:0]       state;
  logic [3:0]       cnt;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             out_of_range, misalign, bad, req, accept, done, we;
  logic [31:0]      cur_word, merged, load_data;

  assign offset       = address - BASE_ADDR;
  assign idx          = offset[IDX_W+1:2];
  assign out_of_range = (address < BASE_ADDR) || (offset[31:2] >= 30'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((mem_size == MEM_HALF) && offset[0]) ||
                    ((mem_size != MEM_BYTE) && (mem_size != MEM_HALF) && (offset[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad = out_of_range | misalign;

  // A request in the reset cycle is ignored so nothing commits while resetting.
  assign req    = (memread | memwrite) & ~reset;
  assign accept = (state == ST_IDLE) & req & ~bad;

  // With no wait states the accepting IDLE cycle is also the completion cycle.
  assign done = ZERO_WS ? accept : ((state == ST_BUSY) && (cnt == 4'd0) && !reset);

  assign stall    = !ZERO_WS && (accept || ((state == ST_BUSY) && (cnt != 4'd0) && !reset));
  assign addr_err = (state == ST_IDLE) & req & bad;
  assign we       = done & memwrite;

  assign cur_word = ram[idx];

  dmem_lane_align u_align (
    .addr_lo      (lane_lo(offset[1:0], mem_size)),
    .size         (mem_size),
    .mem_unsigned (mem_unsigned),
    .write_data   (write_data),
    .word         (cur_word),
    .merged       (merged),
    .load_data    (load_data)
  );

  assign read_data = (done && memread && !memwrite) ? load_data : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: if (accept && !ZERO_WS) begin
          state <= ST_BUSY;
          cnt   <= WS_M1;
        end
        ST_BUSY: if (cnt == 4'd0) state <= ST_IDLE;
                 else             cnt   <= cnt - 4'd1;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Inputs are held stable while stalled, so the live index is the one accepted.
  always_ff @(posedge clk) begin
    if (we) ram[idx] <= merged;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int          DEPTH = 256;
  localparam int          WS    = 1;
  localparam int          WS3   = 3;
  localparam logic [31:0] BASE  = 32'h10010000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, memread, memwrite, mem_unsigned, stall, addr_err;
  logic [1:0]  mem_size;
  logic [31:0] address, write_data, read_data;

  logic        rst3, memread3, memwrite3, mem_unsigned3, stall3, addr_err3;
  logic [1:0]  mem_size3;
  logic [31:0] address3, write_data3, read_data3;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(rst), .memread(memread), .memwrite(memwrite),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .address(address),
    .write_data(write_data), .read_data(read_data), .stall(stall), .addr_err(addr_err)
  );

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS3), .BASE_ADDR(BASE)) dut3 (
    .clk(clk), .reset(rst3), .memread(memread3), .memwrite(memwrite3),
    .mem_size(mem_size3), .mem_unsigned(mem_unsigned3), .address(address3),
    .write_data(write_data3), .read_data(read_data3), .stall(stall3), .addr_err(addr_err3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory is an array of words; rules applied arithmetically.
  function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
    bit b;
    b = (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == MEM_HALF && a[0])           b = 1'b1;
    if (sz == MEM_WORD && a[1:0] != 2'b0) b = 1'b1;
`endif
    return b;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input bit uns);
    logic [31:0] x;
    case (sz)
      MEM_BYTE: begin
        x = (w >> (8 * a[1:0])) & 32'hFF;
        if (!uns && x[7]) x = x | 32'hFFFFFF00;
      end
      MEM_HALF: begin
        x = (w >> (16 * a[1])) & 32'hFFFF;
        if (!uns && x[15]) x = x | 32'hFFFF0000;
      end
      default: x = w;
    endcase
    return x;
  endfunction

  // One access on dut: drives inputs, checks every cycle of it, updates model.
  task automatic acc(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd, input string tag,
                     output logic [31:0] rd_out);
    bit bad;
    int idx, n;
    logic [31:0] exp_rd;
    memread = rd; memwrite = wr; mem_size = sz; mem_unsigned = uns;
    address = a; write_data = wd;
    bad    = is_bad(sz, a);
    idx    = bad ? 0 : int'((a - BASE) >> 2);
    exp_rd = (!bad && rd && !wr) ? load_val(mem[idx], a, sz, uns) : 32'h0;
    n      = bad ? 1 : WS + 1;
    rd_out = 32'h0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk({tag, ".stall"}, 32'(stall), 32'(!bad && c < WS));
      chk({tag, ".err"}, 32'(addr_err), 32'(bad));
      chk({tag, ".rdata"}, read_data, (c == n - 1) ? exp_rd : 32'h0);
      if (c == n - 1) rd_out = read_data;
      @(posedge clk); #1;
    end
    if (!bad && wr) begin
      case (sz)
        MEM_BYTE: mem[idx][8 * a[1:0] +: 8] = wd[7:0];
        MEM_HALF: mem[idx][16 * a[1] +: 16] = wd[15:0];
        default:  mem[idx] = wd;
      endcase
    end
    memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic idle_cyc(input string tag);
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'h0);
    chk({tag, ".err"}, 32'(addr_err), 32'h0);
    chk({tag, ".rdata"}, read_data, 32'h0);
    @(posedge clk); #1;
  endtask

  // Word access on dut3 (WS3 wait states): stall for WS3 cycles then completion.
  task automatic acc3(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] want, input string tag);
    memread3 = rd; memwrite3 = wr; mem_size3 = MEM_WORD; mem_unsigned3 = 1'b0;
    address3 = a; write_data3 = wd;
    for (int c = 0; c <= WS3; c++) begin
      @(negedge clk);
      chk({tag, ".stall"}, 32'(stall3), 32'(c < WS3));
      chk({tag, ".rdata"}, read_data3, (c == WS3) ? want : 32'h0);
      @(posedge clk); #1;
    end
    memread3 = 1'b0; memwrite3 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [1:0]  sz;
    int          op;

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    rst = 1'b1; memread = 1'b0; memwrite = 1'b0; mem_size = MEM_WORD;
    mem_unsigned = 1'b0; address = BASE; write_data = 32'h0;
    rst3 = 1'b1; memread3 = 1'b0; memwrite3 = 1'b0; mem_size3 = MEM_WORD;
    mem_unsigned3 = 1'b0; address3 = BASE; write_data3 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.err", 32'(addr_err), 32'h0);
    chk("rst.rdata", read_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rst3 = 1'b0;
    idle_cyc("post_rst");

    // 1: word store then load
    acc(0, 1, MEM_WORD, 0, BASE, 32'hDEADBEEF, "t1_sw", r);
    acc(1, 0, MEM_WORD, 0, BASE, 32'h0, "t1_lw", r);
    chk("t1_val", r, 32'hDEADBEEF);

    // 2: byte/half extension
    acc(0, 1, MEM_WORD, 0, BASE + 4, 32'h80FF7F01, "t2_sw", r);
    acc(1, 0, MEM_BYTE, 0, BASE + 4, 32'h0, "t2_lb4", r);  chk("t2_lb4_val", r, 32'h00000001);
    acc(1, 0, MEM_BYTE, 0, BASE + 6, 32'h0, "t2_lb6", r);  chk("t2_lb6_val", r, 32'hFFFFFFFF);
    acc(1, 0, MEM_BYTE, 1, BASE + 7, 32'h0, "t2_lbu7", r); chk("t2_lbu7_val", r, 32'h00000080);
    acc(1, 0, MEM_HALF, 0, BASE + 6, 32'h0, "t2_lh6", r);  chk("t2_lh6_val", r, 32'hFFFF80FF);
    acc(1, 0, MEM_HALF, 1, BASE + 6, 32'h0, "t2_lhu6", r); chk("t2_lhu6_val", r, 32'h000080FF);

    // 3: byte store preserves other lanes
    acc(0, 1, MEM_WORD, 0, BASE + 8, 32'h11223344, "t3_sw", r);
    acc(0, 1, MEM_BYTE, 0, BASE + 9, 32'h000000AA, "t3_sb", r);
    acc(1, 0, MEM_WORD, 0, BASE + 8, 32'h0, "t3_lw", r);
    chk("t3_val", r, 32'h1122AA44);

    // 4: misaligned word load
    acc(1, 0, MEM_WORD, 0, BASE + 2, 32'h0, "t4_lw", r);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("t4_val", r, 32'h0);
`else
    chk("t4_val", r, 32'hDEADBEEF);
`endif

    // 5: out of range, loads and stores
    acc(1, 0, MEM_WORD, 0, 32'h0FFFFFFC, 32'h0, "t5_lw_lo", r);
    acc(1, 0, MEM_WORD, 0, BASE + 4 * DEPTH, 32'h0, "t5_lw_hi", r);
    acc(0, 1, MEM_WORD, 0, 32'h0FFFFFFC, 32'h55555555, "t5_sw_lo", r);
    acc(0, 1, MEM_WORD, 0, BASE + 4 * DEPTH, 32'h55555555, "t5_sw_hi", r);
    acc(1, 0, MEM_WORD, 0, BASE + 4 * (DEPTH - 1), 32'h0, "t5_lw_last", r);

    // memread and memwrite together act as a store with no read data
    acc(1, 1, MEM_WORD, 0, BASE + 12, 32'hCAFEF00D, "both", r);
    acc(1, 0, MEM_WORD, 0, BASE + 12, 32'h0, "both_lw", r);
    chk("both_val", r, 32'hCAFEF00D);

    // 6: reset during BUSY cancels the store (dut3)
    memwrite3 = 1'b1; mem_size3 = MEM_WORD; address3 = BASE + 16; write_data3 = 32'h12345678;
    @(negedge clk); chk("t6.req_stall", 32'(stall3), 32'h1);
    @(posedge clk); #1;
    @(negedge clk); chk("t6.busy1_stall", 32'(stall3), 32'h1);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0; memwrite3 = 1'b0;
    @(negedge clk);
    chk("t6.after_stall", 32'(stall3), 32'h0);
    chk("t6.after_err", 32'(addr_err3), 32'h0);
    @(posedge clk); #1;
    acc3(1, 0, BASE + 16, 32'h0, 32'h00000000, "t6_lw");
    acc3(0, 1, BASE + 20, 32'hA5A5C3C3, 32'h0, "t6_sw2");
    acc3(1, 0, BASE + 20, 32'h0, 32'hA5A5C3C3, "t6_lw2");

    // Randomized mix against the reference model
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) != 0)
        a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      else if ($urandom_range(0, 1) != 0)
        a = BASE - 32'($urandom_range(1, 64));
      else
        a = BASE + 4 * DEPTH + 32'($urandom_range(0, 64));
      acc(op < 5, op >= 5 || op == 0, sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd", r);
      if ($urandom_range(0, 3) == 0) idle_cyc("rnd_idle");
    end

    // Sweep every word to confirm no stray writes anywhere
    for (int i = 0; i < DEPTH; i++)
      acc(1, 0, MEM_WORD, 0, BASE + 32'(4 * i), 32'h0, "sweep", r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
